// File: rtl/div_pkg.sv
// div_pkg: state encoding and sizing helpers shared by the restoring divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   localparam logic [63:0] DIV0_QUOTIENT = '1;
   function automatic int clog2(input int v);
      int w = 0;
      while ((1 << w) < v) w++;
      return w;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one compare/subtract stage of the restoring division.
module div_step #(
   parameter int DIVISOR_W = 2
) (
   input  logic [DIVISOR_W:0]   r_shift,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W-1:0] r_next,
   output logic                 q_bit
);
   // Result is below divisor either way, so it always fits in DIVISOR_W bits.
   always_comb begin
      q_bit  = r_shift >= {1'b0, divisor};
      r_next = DIVISOR_W'(q_bit ? r_shift - {1'b0, divisor} : r_shift);
   end
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned divider, one quotient bit per clock.
module restoring_divider
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = 4,
   parameter int DIVISOR_W  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);
   localparam int CW = clog2(DIVIDEND_W);
   state_t state, state_next;
   logic [DIVIDEND_W-1:0] dsr, q;
   logic [DIVISOR_W-1:0] dv, r, r_next;
   logic [CW-1:0] cnt;
   logic dz, q_bit, accept;
   div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .r_shift({r, dsr[DIVIDEND_W-1]}),
      .divisor(dv),
      .r_next(r_next),
      .q_bit(q_bit)
   );
   assign accept = start && (state == IDLE || state == DONE);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_next;
   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = start ? LOAD : IDLE;
         LOAD: state_next = dv == '0 ? DONE : RUN;
         RUN:  state_next = cnt == '0 ? DONE : RUN;
         DONE: state_next = start ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end
   // Operands are captured on accept so the inputs may change while busy.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dsr <= '0;
         dv  <= '0;
         r   <= '0;
         q   <= '0;
         cnt <= '0;
         dz  <= 1'b0;
      end else if (accept) begin
         dsr <= dividend;
         dv  <= divisor;
      end else if (state == LOAD) begin
         r   <= '0;
         cnt <= CW'(DIVIDEND_W - 1);
         dz  <= dv == '0;
         q   <= dv == '0 ? DIV0_QUOTIENT[DIVIDEND_W-1:0] : '0;
      end else if (state == RUN) begin
         dsr <= dsr << 1;
         r   <= r_next;
         q   <= {q[DIVIDEND_W-2:0], q_bit};
         cnt <= cnt - CW'(1);
      end
   assign quotient    = q;
   assign remainder   = r;
   assign div_by_zero = dz;
   assign busy        = state == LOAD || state == RUN;
   assign done        = state == DONE;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and randomized checks against an arithmetic reference.
module tb_restoring_divider;
   logic clk = 1'b0, reset, start;
   logic [3:0] dividend, quotient;
   logic [1:0] divisor, remainder;
   logic busy, done, div_by_zero;
   int checks = 0, failures = 0;

   restoring_divider #(.DIVIDEND_W(4), .DIVISOR_W(2)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for done; n counts edges with the accept edge as edge 1.
   task automatic wait_done(output int n, output int busy_n);
      n = 1;
      busy_n = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) busy_n++;
         step();
         n++;
      end
   endtask

   task automatic check_result(input string tag, input int a, input int b);
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_quot"}, 32'(quotient), b == 0 ? 15 : a / b);
      check({tag, "_rem"}, 32'(remainder), b == 0 ? 0 : a % b);
      check({tag, "_dz"}, 32'(div_by_zero), b == 0 ? 1 : 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic divide(input string tag, input int a, input int b);
      int n, busy_n;
      dividend = 4'(a);
      divisor = 2'(b);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n, busy_n);
      check_result(tag, a, b);
      check({tag, "_lat"}, 32'(n), b == 0 ? 2 : 6);
      check({tag, "_busycyc"}, 32'(busy_n), b == 0 ? 1 : 5);
      if (b != 0) begin
         check({tag, "_contract"}, 32'(int'(quotient) * b + int'(remainder)), 32'(a));
         check({tag, "_rem_lt"}, 32'(int'(remainder) < b), 1);
      end
      step();
      check({tag, "_pulse"}, 32'(done), 0);
      check({tag, "_hold"}, 32'(quotient), b == 0 ? 15 : a / b);
   endtask

   initial begin
      int n, busy_n, seen;
      reset = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) step();
      check("rst_quot", 32'(quotient), 0);
      check("rst_rem", 32'(remainder), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_dz", 32'(div_by_zero), 0);
      reset = 1'b0;
      step();

      divide("d13_3", 13, 3);
      divide("d15_1", 15, 1);
      divide("d2_3", 2, 3);
      divide("d9_3", 9, 3);
      divide("d7_0", 7, 0);
      divide("d6_2", 6, 2);

      // start held with new operands while busy must not disturb the result
      dividend = 13;
      divisor = 3;
      start = 1'b1;
      step();
      dividend = 2;
      divisor = 1;
      repeat (3) step();
      check("ign_busy", 32'(busy), 1);
      start = 1'b0;
      wait_done(n, busy_n);
      check_result("ign", 13, 3);
      step();

      // start held through DONE: the next division is accepted immediately
      dividend = 13;
      divisor = 3;
      start = 1'b1;
      step();
      wait_done(n, busy_n);
      check_result("b2b1", 13, 3);
      dividend = 11;
      divisor = 2;
      step();
      start = 1'b0;
      check("b2b_accept", 32'(busy), 1);
      wait_done(n, busy_n);
      check_result("b2b2", 11, 2);
      check("b2b_gap", 32'(n), 6);
      step();

      // asynchronous reset between edges in the middle of RUN
      dividend = 15;
      divisor = 1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("mid_busy", 32'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check("mid_quot", 32'(quotient), 0);
      check("mid_rem", 32'(remainder), 0);
      check("mid_busy0", 32'(busy), 0);
      check("mid_done", 32'(done), 0);
      check("mid_dz", 32'(div_by_zero), 0);
      step();
      #2 reset = 1'b0;
      seen = 0;
      repeat (10) begin
         step();
         if (done === 1'b1) seen++;
      end
      check("mid_nodone", 32'(seen), 0);
      divide("post_rst", 14, 3);

      for (int i = 0; i < 40; i++)
         divide("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 4; b++)
            divide("sweep", a, b);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
